wave_rom_streamer: RTL and testbench
====================================

# wave_rom_streamer

Upstream stage of the FFT input path. Walks the 128-entry waveform ROM (`ROM_tria128`: 7-bit address, 8-bit data, 1-cycle synchronous read, no output register) with a programmable phase step. Delivers the samples as a framed valid/ready stream to the FFT input buffer. Absorbs the ROM read latency with a 4-deep skid FIFO, so it sustains one sample per clock under continuous `m_ready`.

## Interface
- `ADDR_WIDTH`, 7: ROM address width; the ROM depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: sample width.
- `FRAME_LEN`, 128: samples per frame (1..65535).
- `SIGNED_OUT`, 1: 1 = convert offset-binary ROM data to two's complement by inverting the MSB; 0 = pass the data through unchanged.

- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle start request; ignored while `busy`=1.
- `continuous`  in  1  sampled at each frame's last address issue; 1 = start the next frame back-to-back.
- `step`  in  ADDR_WIDTH  phase increment; latched on an accepted `start`.
- `rom_addr`  out  ADDR_WIDTH  registered address to the ROM.
- `rom_rd_data`  in  DATA_WIDTH  ROM read data.
- `m_data`  out  DATA_WIDTH  sample output.
- `m_valid`  out  1  sample valid.
- `m_ready`  in  1  downstream accept.
- `m_sof`  out  1  first sample of a frame; qualified by `m_valid`.
- `m_eof`  out  1  last sample of a frame; qualified by `m_valid`.
- `busy`  out  1  high from the accepted `start` until the stream is fully drained.
- `frame_cnt`  out  16  count of completed frames (eof handshakes); wraps modulo 2^16.

## Operation
- FSM has three states:
  - IDLE: wait for `start`.
  - ISSUE: issue reads for the current frame.
  - DRAIN: wait for the output to empty.
- Transitions:
  - IDLE → ISSUE on `start`. In that cycle: latch `step`, clear the phase accumulator and issue counter, load `rom_addr`=0, mark an issue.
  - ISSUE, issue rule: an address is issued when `credit = 4 - fifo_count - iss - v1 > 0`.
    - `iss`: the issue-stage flag, set together with `rom_addr`.
    - `v1`: `iss` delayed one cycle; it marks `rom_rd_data` as valid.
    - On each issue: `rom_addr <= rom_addr + step_latched` (mod 2^ADDR_WIDTH, natural wrap) and the issue counter increments. `step`=0 is legal and repeats address 0.
  - ISSUE, frame end: when the issue counter reaches FRAME_LEN-1 and that issue fires:
    - if `continuous`=1: counter → 0, `rom_addr` → 0, stay in ISSUE, no bubble;
    - otherwise → DRAIN.
  - DRAIN → IDLE when `fifo_count`=0, `iss`=0 and `v1`=0. `busy` drops in the same cycle as the IDLE entry.
- Frame tags: sof/eof tags travel with each issued address through `iss`/`v1` and are written into the FIFO with the data. sof = issue index 0; eof = issue index FRAME_LEN-1.
- FIFO: a push happens when `v1`=1. The credit rule guarantees the FIFO never overflows; overflow is a design error.
- Output rules:
  - `m_valid` = FIFO not empty.
  - `m_data`/`m_sof`/`m_eof` come from the FIFO head and hold stable while `m_valid`=1 and `m_ready`=0.
  - A beat transfers when `m_valid`=1 and `m_ready`=1.
  - `frame_cnt` increments on each transfer with `m_eof`=1.
- Simultaneous events:
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - `start` while `busy`=1 is ignored and `step` is not re-latched.
  - `continuous` dropping mid-frame takes effect only at that frame's end.

## Timing
- Reset (`rst_n`=0 at a clk edge): all of the following are cleared at that edge, regardless of state:
  - `rom_addr`=0, `m_valid`=0, `m_sof`=0, `m_eof`=0, `busy`=0, `frame_cnt`=0, `m_data`=0;
  - FSM = IDLE;
  - FIFO, `iss` and `v1` empty.
- Start latency: `start` is sampled at edge E0 and `rom_addr`=0 is driven after E0. The ROM samples it at E1 and the FIFO writes at E2, so `m_valid`=1 after E2, i.e. 2 cycles after the start edge.
- Throughput: with `m_ready` held at 1, one beat per cycle with no bubbles, including across frame boundaries in continuous mode.
- Backpressure: `m_ready`=0 stops issuing within one cycle via credit. Worst-case in-flight reads are 2, and the FIFO peak is 4.
- `busy` rises at E0 and falls one cycle after the final eof handshake.

## Test plan
- Single frame: `step`=1, `SIGNED_OUT`=0, `m_ready`=1, pulse `start`.
  - Expect 128 beats, beat i = ROM[i], `m_sof` on beat 0 only, `m_eof` on beat 127 only.
  - First `m_valid` 2 cycles after the start edge; no gaps.
  - Afterwards `frame_cnt`=1 and `busy`=0.
- Wrap: `step`=3.
  - Beat addresses are 0, 3, …, 126, 1, 4, …; beat 43 reads address 1 (129 mod 128).
  - Data matches the ROM at those addresses.
- Backpressure: `m_ready` is a random 50 % pattern over 2 frames in continuous mode.
  - No lost or duplicated samples.
  - `m_data`/`m_sof`/`m_eof` stable while stalled.
  - FIFO never overflows (assertion).
- Continuous: `continuous`=1 for 3 frames, then drop it.
  - Exactly 384 beats.
  - Beat 128 has `m_sof`=1 and follows beat 127 with no idle cycle.
  - `frame_cnt`=3, then `busy`=0.
- Reset mid-frame: assert `rst_n`=0 for one edge after beat 40.
  - After that edge: `m_valid`=0, `busy`=0, `rom_addr`=0, `frame_cnt`=0.
  - A new `start` then produces a clean frame beginning at ROM[0] with `m_sof`.
- Misc:
  - `start` pulsed mid-frame with `step`=5 is ignored; the frame continues with the original step.
  - With `SIGNED_OUT`=1: ROM 0x00 → `m_data` 0x80, ROM 0xFF → 0x7F.

Source files
------------

// File: rtl/wave_rom_streamer.sv
// Purpose     : walk a waveform ROM with a programmable phase step and stream the samples as framed valid/ready beats.
// Latency     : first m_valid 2 cycles after the start edge (ROM read + FIFO write); one beat per clock when m_ready stays high.
// Backpressure: m_ready low drains credit, so issuing stops within one cycle; at most 4 samples are in flight or buffered.
//
// Ports:
//   clk, rst_n           single clock, synchronous active-low reset
//   start, continuous    one-cycle start request (ignored while busy); back-to-back frame select
//   step                 phase increment, latched on an accepted start
//   rom_addr/rom_rd_data registered ROM address / read data returned one cycle later
//   m_data/m_valid/m_ready/m_sof/m_eof  framed output stream
//   busy, frame_cnt      activity flag; completed-frame counter (eof handshakes)

// Small synchronous FIFO with a combinational head. The storage is reset so
// the head reads zero until the first write.
module stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_vld,
   input  logic [WIDTH-1:0]           wr_dat,
   output logic                       rd_vld,
   input  logic                       rd_rdy,
   output logic [WIDTH-1:0]           rd_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;

   assign rd_vld = (count != '0);
   assign do_rd  = rd_vld && rd_rdy;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_vld, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A write into a full FIFO without a simultaneous pop would lose data.
   always_ff @(posedge clk) begin
      if (rst_n && wr_vld && !do_rd) begin
         assert (count != CW'(DEPTH));
      end
   end
endmodule

module wave_rom_streamer #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 128,
   parameter int SIGNED_OUT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [ADDR_WIDTH-1:0] step,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eof,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);
   localparam int                  FIFO_DEPTH = 4;
   localparam logic [15:0]         LAST_IDX   = 16'(FRAME_LEN - 1);
   // Offset-binary to two's complement is a flip of the MSB.
   localparam logic [DATA_WIDTH-1:0] SIGN_MASK =
      (SIGNED_OUT != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   step_q;
   // Address/index of the next read to issue; preloaded so an issue is a plain copy.
   logic [ADDR_WIDTH-1:0]   nxt_addr;
   logic [15:0]             nxt_idx;

   // iss: address on rom_addr this cycle; v1: rom_rd_data valid this cycle.
   logic                    iss, iss_sof, iss_eof;
   logic                    v1, v1_sof, v1_eof;

   logic [2:0]              fifo_count;
   logic [3:0]              occupancy;
   logic                    credit_ok;
   logic                    fire;
   logic [ADDR_WIDTH-1:0]   fire_addr;
   logic [ADDR_WIDTH-1:0]   fire_step;
   logic [15:0]             fire_idx;
   logic                    fire_last;
   logic                    drained;
   logic [DATA_WIDTH+1:0]   fifo_wr_dat;
   logic [DATA_WIDTH+1:0]   fifo_rd_dat;

   // Every read in the ROM pipe already owns a FIFO slot, so a new read is
   // only issued while the FIFO plus both pipe stages still leave room.
   assign occupancy = {1'b0, fifo_count} + {3'b000, iss} + {3'b000, v1};
   assign credit_ok = (occupancy < 4'd4);
   assign drained   = (fifo_count == 3'd0) && !iss && !v1;

   // The start cycle issues index 0 at address 0 using the incoming step;
   // later issues come from the preloaded next address/index.
   always_comb begin
      fire      = 1'b0;
      fire_addr = nxt_addr;
      fire_step = step_q;
      fire_idx  = nxt_idx;
      if (state == S_IDLE) begin
         fire      = start;
         fire_addr = '0;
         fire_step = step;
         fire_idx  = '0;
      end else if (state == S_ISSUE) begin
         fire      = credit_ok;
      end
      fire_last = (fire_idx == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         step_q    <= '0;
         nxt_addr  <= '0;
         nxt_idx   <= '0;
         rom_addr  <= '0;
         iss       <= 1'b0;
         iss_sof   <= 1'b0;
         iss_eof   <= 1'b0;
         v1        <= 1'b0;
         v1_sof    <= 1'b0;
         v1_eof    <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         iss     <= fire;
         iss_sof <= fire && (fire_idx == 16'd0);
         iss_eof <= fire && fire_last;
         v1      <= iss;
         v1_sof  <= iss_sof;
         v1_eof  <= iss_eof;

         if (fire) begin
            rom_addr <= fire_addr;
            if (fire_last) begin
               // Next frame (if any) restarts the phase at zero.
               nxt_addr <= '0;
               nxt_idx  <= '0;
            end else begin
               nxt_addr <= fire_addr + fire_step;
               nxt_idx  <= fire_idx + 16'd1;
            end
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  step_q <= step;
                  busy   <= 1'b1;
                  state  <= (fire_last && !continuous) ? S_DRAIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (fire && fire_last && !continuous) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drained) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (m_valid && m_ready && m_eof) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign fifo_wr_dat = {v1_sof, v1_eof, rom_rd_data ^ SIGN_MASK};

   stream_fifo #(
      .WIDTH (DATA_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (v1),
      .wr_dat (fifo_wr_dat),
      .rd_vld (m_valid),
      .rd_rdy (m_ready),
      .rd_dat (fifo_rd_dat),
      .count  (fifo_count)
   );

   assign m_sof  = fifo_rd_dat[DATA_WIDTH+1];
   assign m_eof  = fifo_rd_dat[DATA_WIDTH];
   assign m_data = fifo_rd_dat[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_wave_rom_streamer.sv
module tb_wave_rom_streamer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, continuous, m_ready;
   logic [6:0] step, rom_addr;
   logic [7:0] rom_rd_data, m_data;
   logic       m_valid, m_sof, m_eof, busy;
   logic [15:0] frame_cnt;

   // Second instance: signed output, two-sample frames.
   logic       s_start, s_continuous, s_ready;
   logic [6:0] s_step, s_rom_addr;
   logic [7:0] s_rom_rd_data, s_data;
   logic       s_valid, s_sof, s_eof, s_busy;
   logic [15:0] s_frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int t0;
   int exp_fc;
   int busy_fall_cyc;
   logic busy_q = 1'b0;
   logic stall_q = 1'b0;
   logic [9:0] hold_q;

   logic [7:0] beat_dat [$];
   logic       beat_sof [$];
   logic       beat_eof [$];
   int         beat_cyc [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Triangle table: 0,4,...,252 rising then 255,251,...,3 falling.
   function automatic logic [7:0] rom_val(input logic [6:0] a);
      int i;
      i = int'(a);
      if (i < 64) return 8'(i * 4);
      return 8'(255 - (i - 64) * 4);
   endfunction

   always @(posedge clk) rom_rd_data   <= rom_val(rom_addr);
   always @(posedge clk) s_rom_rd_data <= rom_val(s_rom_addr);

   wave_rom_streamer #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .FRAME_LEN(128), .SIGNED_OUT(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .step(step),
      .rom_addr(rom_addr), .rom_rd_data(rom_rd_data), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .frame_cnt(frame_cnt));

   wave_rom_streamer #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .FRAME_LEN(2), .SIGNED_OUT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .continuous(s_continuous), .step(s_step),
      .rom_addr(s_rom_addr), .rom_rd_data(s_rom_rd_data), .m_data(s_data), .m_valid(s_valid),
      .m_ready(s_ready), .m_sof(s_sof), .m_eof(s_eof), .busy(s_busy), .frame_cnt(s_frame_cnt));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat capture and stall-stability check, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_q) check("stall_hold", 32'({m_valid, m_sof, m_eof, m_data}), 32'({1'b1, hold_q}));
         if (m_valid && m_ready) begin
            beat_dat.push_back(m_data);
            beat_sof.push_back(m_sof);
            beat_eof.push_back(m_eof);
            beat_cyc.push_back(cyc);
         end
         stall_q = m_valid && !m_ready;
         hold_q  = {m_sof, m_eof, m_data};
         if (busy_q && !busy) busy_fall_cyc = cyc;
         busy_q = busy;
      end else begin
         stall_q = 1'b0;
         busy_q  = 1'b0;
      end
   end

   task automatic clear_log();
      beat_dat.delete();
      beat_sof.delete();
      beat_eof.delete();
      beat_cyc.delete();
   endtask

   task automatic pulse_start(input logic [6:0] s);
      @(posedge clk); #1;
      step  = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;
      check("busy_rise", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_frames(input string tag, input int nb, input int s, input bit gaps);
      int bad_d, bad_t, bad_g, k;
      bad_d = 0; bad_t = 0; bad_g = 0;
      check({tag, "_count"}, 32'(beat_dat.size()), 32'(nb));
      for (int i = 0; i < beat_dat.size(); i++) begin
         k = i % 128;
         if (beat_dat[i] !== rom_val(7'(k * s))) bad_d++;
         if (beat_sof[i] !== (k == 0) || beat_eof[i] !== (k == 127)) bad_t++;
         if (beat_cyc[i] != beat_cyc[0] + i) bad_g++;
      end
      check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
      check({tag, "_tag_errs"}, 32'(bad_t), 32'd0);
      if (gaps) check({tag, "_gap_errs"}, 32'(bad_g), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; m_ready = 1'b1; step = '0;
      s_start = 1'b0; s_continuous = 1'b0; s_ready = 1'b1; s_step = '0;
      exp_fc = 0; busy_fall_cyc = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_data_tags", 32'({m_sof, m_eof, m_data}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single frame, step 1.
      clear_log();
      pulse_start(7'd1);
      wait_idle("single", 1000);
      exp_fc += 1;
      check_frames("single", 128, 1, 1'b1);
      check("single_first_lat", 32'(beat_cyc[0]), 32'(t0 + 2));
      check("single_fcnt", 32'(frame_cnt), 32'(exp_fc));
      check("single_busy_fall", 32'(busy_fall_cyc), 32'(beat_cyc[127] + 2));

      // Wrap with step 3; a mid-frame start with step 5 must be ignored.
      clear_log();
      pulse_start(7'd3);
      repeat (20) @(posedge clk);
      #1; step = 7'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_idle("wrap", 1000);
      exp_fc += 1;
      check_frames("wrap", 128, 3, 1'b1);
      check("wrap_beat43", 32'(beat_dat[43]), 32'(rom_val(7'd1)));
      check("wrap_fcnt", 32'(frame_cnt), 32'(exp_fc));

      // Random backpressure, two continuous frames, step 7.
      clear_log();
      continuous = 1'b1;
      pulse_start(7'd7);
      for (int k = 0; k < 3000 && busy; k++) begin
         @(posedge clk); #1;
         m_ready = 1'($urandom_range(0, 1));
         if (beat_dat.size() >= 130) continuous = 1'b0;
      end
      m_ready = 1'b1;
      wait_idle("bp", 100);
      exp_fc += 2;
      check_frames("bp", 256, 7, 1'b0);
      check("bp_fcnt", 32'(frame_cnt), 32'(exp_fc));

      // Three back-to-back frames.
      clear_log();
      continuous = 1'b1;
      pulse_start(7'd1);
      for (int k = 0; k < 3000 && busy; k++) begin
         @(posedge clk); #1;
         if (beat_dat.size() >= 260) continuous = 1'b0;
      end
      wait_idle("cont", 100);
      exp_fc += 3;
      check_frames("cont", 384, 1, 1'b1);
      check("cont_b128_sof", 32'(beat_sof[128]), 32'd1);
      check("cont_b128_nogap", 32'(beat_cyc[128]), 32'(beat_cyc[127] + 1));
      check("cont_fcnt", 32'(frame_cnt), 32'(exp_fc));

      // Reset in the middle of a frame.
      clear_log();
      pulse_start(7'd1);
      for (int k = 0; k < 500 && beat_dat.size() < 41; k++) @(negedge clk);
      check("mid_reached_b40", 32'(beat_dat.size() >= 41), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_fc = 0;
      @(negedge clk);
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_addr", 32'(rom_addr), 32'd0);
      check("mid_rst_fcnt", 32'(frame_cnt), 32'(exp_fc));
      clear_log();
      pulse_start(7'd1);
      wait_idle("after_rst", 1000);
      exp_fc += 1;
      check_frames("after_rst", 128, 1, 1'b1);
      check("after_rst_fcnt", 32'(frame_cnt), 32'(exp_fc));

      // Signed output: ROM 0x00 -> 0x80, ROM 0xFF (address 64) -> 0x7F.
      @(posedge clk); #1;
      s_step = 7'd64; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (int k = 0; k < 20 && !s_valid; k++) @(negedge clk);
      check("signed_b0", 32'({s_valid, s_sof, s_eof, s_data}), 32'({3'b110, 8'h80}));
      @(negedge clk);
      check("signed_b1", 32'({s_valid, s_sof, s_eof, s_data}), 32'({3'b101, 8'h7F}));
      repeat (4) @(negedge clk);
      check("signed_fcnt", 32'(s_frame_cnt), 32'd1);
      check("signed_idle", 32'(s_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
